mem_stream_reader: RTL
======================

# mem_stream_reader

Read-side counterpart to the team's byte-RAM writer blocks: on a start command it fetches a run of words from a small synchronous-read memory and streams them out on a valid/ready interface with a last flag. It sits between a `DEPTH`-entry memory read port and a downstream stream consumer. It sustains one word per cycle under no back-pressure and never drops or duplicates data when stalled.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: memory and stream word width.
- `ADDR_WIDTH`, default 2: memory address width. `DEPTH = 2**ADDR_WIDTH`.

Ports (reset `rst_n`, synchronous, active-low; clock `clk`):
- `clk`, in, 1: clock; all logic on rising edge.
- `rst_n`, in, 1: synchronous active-low reset.
- `start`, in, 1: command strobe; sampled only in IDLE.
- `base`, in, `ADDR_WIDTH`: first address, captured with `start`.
- `len`, in, `ADDR_WIDTH+1`: word count, captured with `start`.
- `busy`, out, 1: transfer in progress.
- `done`, out, 1: single-cycle completion pulse.
- `rd_en`, out, 1: memory read strobe.
- `rd_addr`, out, `ADDR_WIDTH`: memory read address.
- `rd_data`, in, `DATA_WIDTH`: read data; valid exactly 1 cycle after `rd_en`.
- `out_data`, out, `DATA_WIDTH`: stream data.
- `out_vld`, out, 1: stream valid.
- `out_rdy`, in, 1: stream ready.
- `out_last`, out, 1: marks the final word of a run.

## Operation
- **FSM states:** IDLE, RUN, DRAIN, FIN.
- **IDLE:** on `start`, capture `base` and `len`.
  - `len > DEPTH` is clamped to `DEPTH`.
  - `len == 0` goes to FIN directly; no `rd_en` and no `out_vld` are produced.
  - Otherwise go to RUN.
- **RUN:**
  - Issue `rd_en` with `rd_addr = base + n mod DEPTH` (address wraps), where n counts issued reads.
  - Issue a read only when `occupancy + inflight - pop < 2`.
    - `occupancy` is the number of words held in the 2-entry output FIFO.
    - `inflight` is 1 if `rd_en` was asserted in the previous cycle.
    - `pop` is `out_vld & out_rdy` in the current cycle.
  - After the last read is issued, go to DRAIN.
- **DRAIN:** wait until the final word is handshaken, then go to FIN.
- **FIN:** assert `done` for one cycle, then return to IDLE.
- **Data capture:** `rd_data` is pushed into the FIFO in the cycle after `rd_en`; it is never dropped.
- **Stream output:** `out_data` and `out_last` are the FIFO head.
  - Both must be stable while `out_vld && !out_rdy`.
  - `out_last` is high only together with the word of index `len-1`.
- **Command handling:** `start` while not in IDLE is ignored; no queuing of commands.
- **Ordering:** words are emitted in address-issue order.

## Timing
- **Reset values:** `busy`, `done`, `rd_en`, `out_vld` and `out_last` are 0; `rd_addr` and `out_data` are 0.
  - Reset also clears the FIFO, the counters and the in-flight flag, and forces IDLE.
  - Reset mid-transfer aborts the transfer with no `done` pulse. A read returning after reset is discarded.
- **Latency:** `start` sampled at edge of cycle 0.
  - First `rd_en` in cycle 1.
  - First `rd_data` in cycle 2.
  - First `out_vld` in cycle 3.
- **Throughput:** with `out_rdy` held high, one word per cycle.
- **`busy`:** high from cycle 1 through the cycle of the final handshake.
- **`done`:** pulses in the following cycle.
- **`len == 0`:**
  - `busy` stays 0.
  - `done` pulses in cycle 1.
- **FIFO bound:** occupancy never exceeds 2.
- **Simultaneous push and pop:** occupancy is unchanged.

## Structure
- Package `mem_stream_pkg`:
  - state enum `mem_stream_state_t` (IDLE, RUN, DRAIN, FIN);
  - default width constants;
  - a `clamp_len` function.
- One sub-module `reg_fifo2`: a 2-entry register FIFO with push, pop, head, count and synchronous active-low clear, parameterised on `DATA_WIDTH + 1` (data plus last flag).

## Test plan
Memory model: `mem[i] = 0x10 + i`, 1-cycle read latency.

1. `base=0`, `len=4`, `out_rdy=1`:
   - `out_data` is 0x10, 0x11, 0x12, 0x13 in cycles 3-6, with `out_last` on 0x13.
   - `busy` is high in cycles 1-6; `done` pulses in cycle 7.
2. Wrap-around, `base=3`, `len=3`:
   - `rd_addr` sequence is 3, 0, 1.
   - Output is 0x13, 0x10, 0x11 with `out_last` on 0x11.
3. Back-pressure, `base=0`, `len=4`, `out_rdy=0` in cycles 3-8:
   - `out_data` holds 0x10 and `out_last` stays 0.
   - At most 2 reads are issued before the first pop.
   - After release, all 4 words arrive in order, with no loss or duplicates.
4. Length edge cases:
   - `len=0`: `done` pulses in cycle 1, with no `rd_en` and no `out_vld`.
   - `len=7`: clamped, giving exactly 4 words, 0x10-0x13.
5. `start` pulsed again in cycle 2 of a `len=4` run:
   - The pulse is ignored; exactly 4 words and a single `done`.
6. `rst_n=0` in cycle 4 of a `len=4` run:
   - Cycle 5: all outputs at their reset values, no `done`.
   - A new `start` with `base=1`, `len=2` then yields 0x11, 0x12 normally.

Source files
------------

// File: rtl/mem_stream_pkg.sv
// Shared types and constants for the memory stream reader and its output FIFO.
package mem_stream_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } mem_stream_state_t;

    // A run can never be longer than the memory itself.
    function automatic int clamp_len(input int req_len, input int depth);
        return (req_len > depth) ? depth : req_len;
    endfunction

endpackage

// File: rtl/mem_stream_reader_fifo.sv
// Two-entry register FIFO; entry0 is always the head so the output is a plain flop.
module reg_fifo2 #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] entry0_q, entry0_d;
    logic [WIDTH-1:0] entry1_q, entry1_d;
    logic [1:0]       count_q, count_d;

    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    entry0_d = din;
                    count_d  = 2'd1;
                end else if (count_q == 2'd1) begin
                    entry1_d = din;
                    count_d  = 2'd2;
                end
            end
            2'b01: begin
                if (count_q != 2'd0) begin
                    entry0_d = entry1_q;
                    count_d  = count_q - 2'd1;
                end
            end
            2'b11: begin
                // Simultaneous push and pop keeps occupancy; only the data shifts.
                if (count_q == 2'd2) begin
                    entry0_d = entry1_q;
                    entry1_d = din;
                end else if (count_q == 2'd1) begin
                    entry0_d = din;
                end else begin
                    entry0_d = din;
                    count_d  = 2'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= 2'd0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
        end
    end

    assign head  = entry0_q;
    assign count = count_q;

endmodule

// File: rtl/mem_stream_reader.sv
// Fetches a run of words from a synchronous-read memory and streams them out
// on a valid/ready interface, throttling reads so the 2-entry FIFO never overflows.
module mem_stream_reader
    import mem_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic                  out_last
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LW    = ADDR_WIDTH + 1;

    mem_stream_state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LW-1:0]         len_q, len_d;
    logic [LW-1:0]         issued_q, issued_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [LW-1:0]         len_clamped;
    logic [DATA_WIDTH:0]   fifo_head;
    logic [1:0]            fifo_count;
    logic                  pop;
    logic                  can_issue;
    logic                  issue_last;

    assign len_clamped = LW'(clamp_len(32'(len), DEPTH));

    assign out_vld  = (fifo_count != 2'd0);
    assign out_data = fifo_head[DATA_WIDTH-1:0];
    assign out_last = out_vld & fifo_head[DATA_WIDTH];
    assign pop      = out_vld & out_rdy;

    // A new read is safe if words held plus the one returning, minus this pop, leave a free slot.
    assign can_issue  = ({1'b0, fifo_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
    assign rd_en      = (state_q == RUN) && can_issue;
    assign rd_addr    = addr_q;
    assign issue_last = (issued_q == (len_q - LW'(1)));

    assign busy = busy_q;
    assign done = done_q;

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        len_d           = len_q;
        issued_d        = issued_q;
        inflight_d      = rd_en;
        inflight_last_d = rd_en & issue_last;
        busy_d          = busy_q;
        done_d          = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d   = base;
                    len_d    = len_clamped;
                    issued_d = '0;
                    if (len_clamped == '0) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (rd_en) begin
                    addr_d   = addr_q + ADDR_WIDTH'(1);
                    issued_d = issued_q + LW'(1);
                    if (issue_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    state_d = FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Clearing the in-flight flag on reset is what discards a read returning after an abort.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            len_q           <= '0;
            issued_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            len_q           <= len_d;
            issued_q        <= issued_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    reg_fifo2 #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_fifo (
        .clk  (clk),
        .clr_n(rst_n),
        .push (inflight_q),
        .pop  (pop),
        .din  ({inflight_last_q, rd_data}),
        .head (fifo_head),
        .count(fifo_count)
    );

endmodule
